// File: rtl/pwm_duty_decoder_pkg.sv
// Shared types and helpers for the PWM duty decoder: FSM state encoding,
// signed 12-bit speed limits and the saturating narrowing function.
package pwm_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALE
  } state_t;

  localparam logic signed [11:0] SPD_MAX = 12'sh7FF;
  localparam logic signed [11:0] SPD_MIN = 12'sh800;

  function automatic logic signed [11:0] sat12(input logic signed [31:0] val);
    if (val > 32'sd2047) return SPD_MAX;
    if (val < -32'sd2048) return SPD_MIN;
    return 12'(val);
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_edge_sample.sv
// One PWM leg: optional 2-flop synchronizer (PWM_DEC_SYNC_EN), sampling
// register and rising-edge detect against the previous sample.
module pwm_edge_sample (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm,
  output logic samp,
  output logic rise
);

  logic in_q;
  logic prev;

`ifdef PWM_DEC_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm;
      sync2 <= sync1;
    end
  end

  assign in_q = sync2;
`else
  assign in_q = pwm;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp <= 1'b0;
      prev <= 1'b0;
    end else begin
      samp <= in_q;
      prev <= samp;
    end
  end

  assign rise = samp & ~prev;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the signed 12-bit speed from a complementary PWM pair, with stale
// and sticky shoot-through detection. PWM_DEC_SYNC_EN adds input synchronizers.
module pwm_duty_decoder
  import pwm_dec_pkg::*;
#(
  parameter int CNT_W   = 13,
  parameter int TIMEOUT = 8192,
  parameter bit INVERT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PWM1,
  input  logic                    PWM2,
  input  logic                    clr_flt,
  output logic signed [11:0]      spd,
  output logic [CNT_W-1:0]        period,
  output logic                    vld,
  output logic                    stale,
  output logic                    shoot_thru
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic p1, p2, rise;
  logic [CNT_W-1:0] per, hi1, hi2, since_edge;
  logic timeout;
  logic signed [CNT_W:0] diff, half;
  logic signed [11:0] meas_spd, stale_spd;
  logic load_meas, load_stale, clr_stale;
  state_t state, state_nxt;

  pwm_edge_sample u_leg1 (.clk(clk), .rst_n(rst_n), .pwm(PWM1), .samp(p1), .rise(rise));
  pwm_edge_sample u_leg2 (.clk(clk), .rst_n(rst_n), .pwm(PWM2), .samp(p2), .rise());

  function automatic logic signed [11:0] orient(input logic signed [11:0] v);
    if (INVERT) return sat12(32'sd0 - 32'(v));
    return v;
  endfunction

  // Counters restart on every PWM1 rise, counting the rise cycle itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per        <= '0;
      hi1        <= '0;
      hi2        <= '0;
      since_edge <= '0;
    end else if (rise) begin
      per        <= CNT_W'(1);
      hi1        <= CNT_W'(1);
      hi2        <= CNT_W'(p2);
      since_edge <= '0;
    end else begin
      if (per != CNT_MAX) per <= per + 1'b1;
      if (p1 && hi1 != CNT_MAX) hi1 <= hi1 + 1'b1;
      if (p2 && hi2 != CNT_MAX) hi2 <= hi2 + 1'b1;
      if (since_edge != CNT_MAX) since_edge <= since_edge + 1'b1;
    end
  end

  assign timeout  = (32'(since_edge) >= 32'(TIMEOUT - 1));
  assign diff     = $signed({1'b0, hi1}) - $signed({1'b0, hi2});
  assign half     = diff >>> 1;
  assign meas_spd = sat12(32'(half));

  always_comb begin
    stale_spd = 12'sd0;
    if (p1)      stale_spd = SPD_MAX;
    else if (p2) stale_spd = SPD_MIN;
  end

  always_comb begin
    state_nxt  = state;
    load_meas  = 1'b0;
    load_stale = 1'b0;
    clr_stale  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = MEASURE;
        else if (timeout) begin
          state_nxt  = STALE;
          load_stale = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) load_meas = 1'b1;
        else if (timeout) begin
          state_nxt  = STALE;
          load_stale = 1'b1;
        end
      end
      STALE: begin
        // The period that ends here is partial, so no measurement is reported.
        if (rise) begin
          state_nxt = MEASURE;
          clr_stale = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      spd        <= '0;
      period     <= '0;
      vld        <= 1'b0;
      stale      <= 1'b0;
      shoot_thru <= 1'b0;
    end else begin
      state <= state_nxt;
      vld   <= load_meas | load_stale;
      if (load_meas) begin
        spd    <= orient(meas_spd);
        period <= per;
      end else if (load_stale) begin
        spd    <= orient(stale_spd);
        period <= '0;
        stale  <= 1'b1;
      end
      if (clr_stale) stale <= 1'b0;
      if (p1 && p2)     shoot_thru <= 1'b1;
      else if (clr_flt) shoot_thru <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: a normal and an INVERT=1 instance share
// the same PWM stimulus; expectations are hand-computed per scenario.
module tb_pwm_duty_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PWM1 = 1'b0;
  logic PWM2 = 1'b0;
  logic clr_flt = 1'b0;

  logic signed [11:0] spd, spd_inv;
  logic [12:0] period, period_inv;
  logic vld, vld_inv, stale, stale_inv, shoot_thru, shoot_thru_inv;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int vld_cnt = 0;
  int vld_inv_cnt = 0;
  int cap_lat = 0;
  logic signed [11:0] cap_spd = '0;
  logic signed [11:0] cap_spd_inv = '0;
  logic [12:0] cap_period = '0;
  logic [12:0] cap_period_inv = '0;

`ifdef PWM_DEC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  always #5 clk = ~clk;

  pwm_duty_decoder #(.CNT_W(13), .TIMEOUT(8192), .INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_flt(clr_flt),
    .spd(spd), .period(period), .vld(vld), .stale(stale), .shoot_thru(shoot_thru)
  );

  pwm_duty_decoder #(.CNT_W(13), .TIMEOUT(8192), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_flt(clr_flt),
    .spd(spd_inv), .period(period_inv), .vld(vld_inv), .stale(stale_inv),
    .shoot_thru(shoot_thru_inv)
  );

  // One iteration per clock: sample outputs at the falling edge, then drive.
  task automatic applyStimulus(input int n, input logic a, input logic b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (vld === 1'b1) begin
        vld_cnt++;
        cap_spd    = spd;
        cap_period = period;
        cap_lat    = cyc - rise_cyc;
      end
      if (vld_inv === 1'b1) begin
        vld_inv_cnt++;
        cap_spd_inv    = spd_inv;
        cap_period_inv = period_inv;
      end
      if (a && !PWM1) rise_cyc = cyc;
      PWM1 = a;
      PWM2 = b;
    end
  endtask

  task automatic pwmPeriod(input int h1, input int g1, input int h2, input int g2);
    applyStimulus(h1, 1'b1, 1'b0);
    applyStimulus(g1, 1'b0, 1'b0);
    applyStimulus(h2, 1'b0, 1'b1);
    applyStimulus(g2, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearCaptures();
    vld_cnt     = 0;
    vld_inv_cnt = 0;
  endtask

  initial begin
    $display("[TB] start, input-to-output latency %0d", LAT);

    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("rst_spd", spd, 0);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_vld", vld, 0);
    checkOutput("rst_stale", stale, 0);
    checkOutput("rst_shoot", shoot_thru, 0);

    rst_n = 1'b1;
    clearCaptures();
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("first_rise_no_vld", vld_cnt, 0);
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("ideal_vld_cnt", vld_cnt, 1);
    checkOutput("ideal_spd", cap_spd, 1024);
    checkOutput("ideal_period", cap_period, 4096);
    checkOutput("ideal_latency", cap_lat, LAT);
    checkOutput("ideal_spd_inv", cap_spd_inv, -1024);

    pwmPeriod(3040, 32, 992, 32);
    clearCaptures();
    pwmPeriod(2016, 32, 2016, 32);
    checkOutput("dead_vld_cnt", vld_cnt, 1);
    checkOutput("dead_spd", cap_spd, 1024);
    checkOutput("dead_period", cap_period, 4096);
    clearCaptures();
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("half_spd", cap_spd, 0);
    checkOutput("half_spd_inv", cap_spd_inv, 0);

    pwmPeriod(7999, 1, 0, 0);
    clearCaptures();
    pwmPeriod(1, 0, 7999, 0);
    checkOutput("satp_vld_cnt", vld_cnt, 1);
    checkOutput("satp_spd", cap_spd, 2047);
    checkOutput("satp_spd_inv", cap_spd_inv, -2047);
    checkOutput("satp_period", cap_period, 8000);
    clearCaptures();
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("satn_spd", cap_spd, -2048);
    checkOutput("satn_spd_inv", cap_spd_inv, 2047);
    checkOutput("satn_period_inv", cap_period_inv, 8000);

    clearCaptures();
    applyStimulus(8150, 1'b1, 1'b0);
    checkOutput("pre_stale_vld_cnt", vld_cnt, 1);
    checkOutput("pre_stale_flag", stale, 0);
    clearCaptures();
    applyStimulus(200, 1'b1, 1'b0);
    checkOutput("stale_flag", stale, 1);
    checkOutput("stale_flag_inv", stale_inv, 1);
    checkOutput("stale_vld_cnt", vld_cnt, 1);
    checkOutput("stale_spd", cap_spd, 2047);
    checkOutput("stale_spd_inv", cap_spd_inv, -2047);
    checkOutput("stale_period", cap_period, 0);

    clearCaptures();
    applyStimulus(16, 1'b0, 1'b1);
    applyStimulus(4, 1'b1, 1'b0);
    checkOutput("resume_stale_clr", stale, 0);
    checkOutput("resume_no_vld", vld_cnt, 0);
    applyStimulus(3068, 1'b1, 1'b0);
    applyStimulus(1024, 1'b0, 1'b1);
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("resume_vld_cnt", vld_cnt, 1);
    checkOutput("resume_spd", cap_spd, 1024);
    checkOutput("resume_period", cap_period, 4096);

    checkOutput("shoot_idle", shoot_thru, 0);
    applyStimulus(1, 1'b1, 1'b1);
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("shoot_set", shoot_thru, 1);
    checkOutput("shoot_set_inv", shoot_thru_inv, 1);
    applyStimulus(1, 1'b1, 1'b1);
    applyStimulus(LAT - 1, 1'b0, 1'b0);
    clr_flt = 1'b1;
    applyStimulus(1, 1'b0, 1'b0);
    clr_flt = 1'b0;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("shoot_set_wins", shoot_thru, 1);
    clr_flt = 1'b1;
    applyStimulus(1, 1'b0, 1'b0);
    clr_flt = 1'b0;
    applyStimulus(2, 1'b0, 1'b0);
    checkOutput("shoot_clear", shoot_thru, 0);

    applyStimulus(1000, 1'b1, 1'b0);
    checkOutput("pre_rst_period_nonzero", (period != 0), 1);
    rst_n = 1'b0;
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("midrst_spd", spd, 0);
    checkOutput("midrst_period", period, 0);
    checkOutput("midrst_vld", vld, 0);
    checkOutput("midrst_stale", stale, 0);
    applyStimulus(2, 1'b0, 1'b0);
    rst_n = 1'b1;
    clearCaptures();
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("postrst_no_vld", vld_cnt, 0);
    pwmPeriod(3072, 0, 1024, 0);
    checkOutput("postrst_vld_cnt", vld_cnt, 1);
    checkOutput("postrst_spd", cap_spd, 1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
